wb_port_scheduler: RTL

//  Shares the single register-file write port between the fixed-latency pipeline WB and the multi-cycle
//  MUL/DIV unit (MDU). Keeps a per-register scoreboard of outstanding MDU destinations.

---
 rtl/wb_port_scheduler_pkg.sv | 10 +
 rtl/wb_port_scheduler_regs_scoreboard.sv | 53 +++++
 rtl/wb_port_scheduler.sv | 92 +++++++++
 3 files changed

// File: rtl/wb_port_scheduler_pkg.sv
// wb_port_scheduler_pkg: shared types and constants for the write-port scheduler
package wb_port_scheduler_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic                we;
        logic [4:0]          addr;
        logic [XLEN_DEF-1:0] data;
    } rf_wr_req_t;
endpackage

// File: rtl/wb_port_scheduler_regs_scoreboard.sv
// wb_port_scheduler_regs_scoreboard: per-register pending bits and outstanding MDU op count
//   clk, reset (async active-low)
//   set_en/set_addr  : mark a register pending (MDU issue)
//   clr_en/clr_addr  : clear a pending register (MDU retire)
//   rs1, rs2, rd, rd_we : ID operands checked for RAW/WAW
//   hazard           : an ID operand hits a pending register
//   full             : outstanding count is at MAX_PENDING
//   pending          : registered pending vector, bit 0 always 0
module wb_port_scheduler_regs_scoreboard
    import wb_port_scheduler_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic [4:0]  set_addr,
    input  logic        clr_en,
    input  logic [4:0]  clr_addr,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        rd_we,
    output logic        hazard,
    output logic        full,
    output logic [31:0] pending
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [31:1]   pending_q;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            count     <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                pending_q[i] <= (set_en && set_addr == 5'(i)) ? 1'b1 :
                                (clr_en && clr_addr == 5'(i)) ? 1'b0 : pending_q[i];
            count <= count + CW'(set_en) - CW'(clr_en);
        end
    end

    assign pending = {pending_q, 1'b0};
    assign hazard  = pending[rs1] | pending[rs2] | (rd_we & pending[rd]);
    assign full    = count == CW'(MAX_PENDING);

    a_overflow: assert property (@(posedge clk) disable iff (!reset)
        (set_en && !clr_en) |-> !full);
    a_underflow: assert property (@(posedge clk) disable iff (!reset)
        (clr_en && !set_en) |-> count != '0);
endmodule

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: arbitrates the RF write port between pipeline WB and MDU results
//   clk, reset (async active-low)
//   id_*        : ID operands and MDU issue; stall_id holds IF/ID on hazards or a full scoreboard
//   wb_*        : pipeline write-back request, always wins the port
//   mdu_*       : MDU result handshake into a one-entry holding register
//   rf_*        : register-file write port
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rd_we,
    input  logic            issue_valid,
    output logic            stall_id,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);
    logic            hold_valid;
    logic [4:0]      hold_rd;
    logic [XLEN-1:0] hold_data;
    logic            wb_sel;
    logic            drain;
    logic            accept;
    logic            issue;
    logic            hazard;
    logic            full;
    logic [31:0]     pending;

    assign wb_sel    = wb_RegWrite && wb_rd_addr != REG_ZERO;
    assign drain     = hold_valid && !wb_sel;
    assign mdu_ready = !hold_valid;
    assign accept    = mdu_valid && mdu_ready;
    assign stall_id  = hazard | (issue_valid & full);
    assign issue     = issue_valid && !stall_id && id_rd_addr != REG_ZERO;

    always_comb begin
        rf_we    = wb_sel | hold_valid;
        rf_waddr = wb_sel ? wb_rd_addr : hold_valid ? hold_rd : REG_ZERO;
        rf_wdata = wb_sel ? wb_rd_data : hold_valid ? hold_data : '0;
    end

    // The hold only loads while empty, so its contents stay stable until drained.
    // Results for x0 are acknowledged but never captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_rd    <= REG_ZERO;
            hold_data  <= '0;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end else if (accept && mdu_rd != REG_ZERO) begin
            hold_valid <= 1'b1;
            hold_rd    <= mdu_rd;
            hold_data  <= mdu_data;
        end
    end

    wb_port_scheduler_regs_scoreboard #(.MAX_PENDING(MAX_PENDING)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue),
        .set_addr (id_rd_addr),
        .clr_en   (drain),
        .clr_addr (hold_rd),
        .rs1      (id_rs1_addr),
        .rs2      (id_rs2_addr),
        .rd       (id_rd_addr),
        .rd_we    (id_rd_we),
        .hazard   (hazard),
        .full     (full),
        .pending  (pending)
    );

    a_mdu_not_pending: assert property (@(posedge clk) disable iff (!reset)
        (accept && mdu_rd != REG_ZERO) |-> pending[mdu_rd]);
    a_wb_to_pending: assert property (@(posedge clk) disable iff (!reset)
        wb_sel |-> !pending[wb_rd_addr]);
endmodule
